// File: rtl/sad_engine.sv
// sad_engine: sum-of-absolute-differences search over NCH candidate channels.
// A WIN_WORDS window of packed 8-bit pixels is shifted in while the block is
// idle. Each search run accumulates one SAD per channel, picks the channel
// with the smallest SAD, and folds that result into a running minimum.
module sad_engine #(
    parameter int NCH        = 2,
    parameter int WIN_WORDS  = 16,
    parameter int TAG_STRIDE = 256
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              win_shift,
    input  logic [31:0]       win_data,
    input  logic              start,
    input  logic [31:0]       base_tag,
    input  logic              frm_valid,
    input  logic [32*NCH-1:0] frm_data,
    input  logic              clear_min,
    input  logic              sel_min,
    output logic              busy,
    output logic              done,
    output logic [31:0]       min_sad,
    output logic [31:0]       min_tag,
    output logic [31:0]       rd_data
);
    localparam int SAD_W = $clog2(WIN_WORDS*4*255+1);
    localparam int CNT_W = $clog2(WIN_WORDS);
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIN_WORDS-1);
    localparam logic [31:0]      MIN_INIT = (32'd1 << SAD_W) - 32'd1;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_COMPARE, S_DONE} state_e;

    state_e                            state_q, state_d;
    logic [WIN_WORDS-1:0][31:0]        win_q;
    logic [NCH-1:0][SAD_W-1:0]         acc_q;
    logic [CNT_W-1:0]                  cnt_q;
    logic [31:0]                       tag_q;
    logic [31:0]                       min_sad_q, min_tag_q;

    logic [31:0]                       cur_w;
    logic [NCH-1:0][9:0]               beat_sad;
    logic [IDX_W-1:0]                  best_idx;
    logic [SAD_W-1:0]                  best_acc;
    logic [31:0]                       best_tag;
    logic                              last_beat;

    // SAD of four byte lanes; at most 4*255, fits in 10 bits
    function automatic logic [9:0] sad4(input logic [31:0] a, input logic [31:0] b);
        logic [9:0] s;
        logic [7:0] x, y;
        s = '0;
        for (int k = 0; k < 4; k++) begin
            x = a[8*k +: 8];
            y = b[8*k +: 8];
            s = s + 10'((x > y) ? (x - y) : (y - x));
        end
        return s;
    endfunction

    assign cur_w     = win_q[cnt_q];
    assign last_beat = frm_valid && (cnt_q == CNT_LAST);

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        assign beat_sad[c] = sad4(cur_w, frm_data[32*c +: 32]);
    end

    // Pick the smallest accumulator; strict compare keeps the lowest index on ties
    always_comb begin
        best_idx = '0;
        best_acc = acc_q[0];
        for (int c = 1; c < NCH; c++) begin
            if (acc_q[c] < best_acc) begin
                best_acc = acc_q[c];
                best_idx = c[IDX_W-1:0];
            end
        end
        best_tag = tag_q + 32'(best_idx) * 32'(TAG_STRIDE);
    end

    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state and status outputs
    always_comb begin
        state_d = state_q;
        busy    = 1'b1;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_d = S_ACCUM;
            end
            S_ACCUM:   if (last_beat) state_d = S_COMPARE;
            S_COMPARE: state_d = S_DONE;
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default:   state_d = S_IDLE;
        endcase
    end

    // Window shift register, run setup and per-beat accumulation
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            win_q <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            tag_q <= '0;
        end else begin
            if (state_q == S_IDLE) begin
                if (win_shift) win_q <= {win_data, win_q[WIN_WORDS-1:1]};
                if (start) begin
                    tag_q <= base_tag;
                    acc_q <= '0;
                    cnt_q <= '0;
                end
            end else if (state_q == S_ACCUM && frm_valid) begin
                for (int c = 0; c < NCH; c++)
                    acc_q[c] <= acc_q[c] + SAD_W'(beat_sad[c]);
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Running minimum; clear_min overrides a same-edge update
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            min_sad_q <= MIN_INIT;
            min_tag_q <= '0;
        end else if (clear_min) begin
            min_sad_q <= MIN_INIT;
            min_tag_q <= '0;
        end else if (state_q == S_COMPARE &&
                     {{(32-SAD_W){1'b0}}, best_acc} < min_sad_q) begin
            min_sad_q <= {{(32-SAD_W){1'b0}}, best_acc};
            min_tag_q <= best_tag;
        end
    end

    assign min_sad = min_sad_q;
    assign min_tag = min_tag_q;
    assign rd_data = sel_min ? min_sad_q : min_tag_q;

endmodule

// File: tb/tb_sad_engine.sv
// Bench for sad_engine: directed scenarios plus randomized runs, all checked
// every cycle against a transaction-level model that computes SADs from the
// stored window and collected beats with plain arithmetic.
module tb_sad_engine;
    localparam int NCH = 2, WIN = 16, STRIDE = 256;
    localparam logic [31:0] MINI = 32'h3FFF;

    logic              Clk = 0, Reset = 0;
    logic              win_shift = 0, start = 0, frm_valid = 0, clear_min = 0, sel_min = 0;
    logic [31:0]       win_data = 0, base_tag = 0;
    logic [32*NCH-1:0] frm_data = '0;
    logic              busy, done;
    logic [31:0]       min_sad, min_tag, rd_data;

    sad_engine #(.NCH(NCH), .WIN_WORDS(WIN), .TAG_STRIDE(STRIDE)) dut (
        .Clk(Clk), .Reset(Reset), .win_shift(win_shift), .win_data(win_data),
        .start(start), .base_tag(base_tag), .frm_valid(frm_valid), .frm_data(frm_data),
        .clear_min(clear_min), .sel_min(sel_min), .busy(busy), .done(done),
        .min_sad(min_sad), .min_tag(min_tag), .rd_data(rd_data));

    always #5 Clk = ~Clk;

    int n_vec = 0, n_err = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int                m_phase = 0;  // 0 idle, 1 gathering beats, 2 choosing, 3 reporting
    logic [31:0]       m_win[WIN];
    logic [31:0]       m_tag, m_min_sad, m_min_tag, m_best_tag;
    int                m_best_sad;
    int                m_sads[NCH];
    logic [32*NCH-1:0] m_beats[$];

    function automatic int word_sad(input logic [31:0] a, input logic [31:0] b);
        int s = 0, d;
        for (int k = 0; k < 4; k++) begin
            d = int'(a[8*k +: 8]) - int'(b[8*k +: 8]);
            s += (d < 0) ? -d : d;
        end
        return s;
    endfunction

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            m_phase = 0;
            foreach (m_win[i]) m_win[i] = 0;
            m_tag = 0; m_min_sad = MINI; m_min_tag = 0;
            m_beats.delete();
        end else begin
            case (m_phase)
                0: begin
                    if (win_shift) begin
                        for (int i = 0; i < WIN-1; i++) m_win[i] = m_win[i+1];
                        m_win[WIN-1] = win_data;
                    end
                    if (start) begin
                        m_tag = base_tag; m_beats.delete(); m_phase = 1;
                    end
                end
                1: if (frm_valid) begin
                    m_beats.push_back(frm_data);
                    if (m_beats.size() == WIN) begin
                        int bidx;
                        bidx = 0;
                        for (int c = 0; c < NCH; c++) begin
                            m_sads[c] = 0;
                            for (int i = 0; i < WIN; i++)
                                m_sads[c] += word_sad(m_win[i], m_beats[i][32*c +: 32]);
                            if (c == 0 || m_sads[c] < m_sads[bidx]) bidx = c;
                        end
                        m_best_sad = m_sads[bidx];
                        m_best_tag = m_tag + 32'(bidx * STRIDE);
                        m_phase = 2;
                    end
                end
                2: begin
                    if (32'(m_best_sad) < m_min_sad) begin
                        m_min_sad = 32'(m_best_sad); m_min_tag = m_best_tag;
                    end
                    m_phase = 3;
                end
                default: m_phase = 0;
            endcase
            if (clear_min) begin
                m_min_sad = MINI; m_min_tag = 0;
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge Clk) begin
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(m_phase != 0));
            chk("done", 32'(done), 32'(m_phase == 3));
            chk("min_sad", min_sad, m_min_sad);
            chk("min_tag", min_tag, m_min_tag);
            chk("rd_data", rd_data, sel_min ? m_min_sad : m_min_tag);
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] win_tab[WIN];
    logic [31:0] frm_tab[WIN][NCH];
    int          stall_tab[WIN];

    task automatic tick();
        @(posedge Clk); #1;
        sel_min = 1'($urandom);
    endtask

    task automatic load_win();
        for (int i = 0; i < WIN; i++) begin
            win_shift = 1; win_data = win_tab[i]; tick();
        end
        win_shift = 0;
    endtask

    task automatic junk_frame();
        for (int c = 0; c < NCH; c++) frm_data[32*c +: 32] = $urandom;
    endtask

    task automatic pulse_clear();
        clear_min = 1; tick(); clear_min = 0;
    endtask

    // One search run; lat counts edges from the start edge until done is seen
    task automatic run(input logic [31:0] tag, input bit noise, input bit clr_cmp, output int lat);
        base_tag = tag; start = 1; tick(); start = 0; lat = 0;
        for (int i = 0; i < WIN; i++) begin
            frm_valid = 1;
            for (int c = 0; c < NCH; c++) frm_data[32*c +: 32] = frm_tab[i][c];
            if (noise) begin
                win_shift = 1; win_data = $urandom; start = 1'($urandom);
            end
            tick(); lat++;
            frm_valid = 0; junk_frame();
            for (int s = 0; s < stall_tab[i]; s++) begin tick(); lat++; end
        end
        win_shift = 0; start = 0;
        if (clr_cmp) begin clear_min = 1; tick(); lat++; clear_min = 0; end
        while (done !== 1'b1 && lat < 200) begin tick(); lat++; end
        if (done !== 1'b1) chk("done_timeout", 32'(done), 32'd1);
        tick();
    endtask

    task automatic set_basic(input logic [31:0] ch0, input logic [31:0] ch1);
        for (int i = 0; i < WIN; i++) begin
            win_tab[i] = 32'h10101010;
            frm_tab[i][0] = ch0; frm_tab[i][1] = ch1;
            stall_tab[i] = 0;
        end
    endtask

    initial begin
        int lat;
        // Reset state
        Reset = 1; tick(); tick();
        chk_en = 1;
        sel_min = 0; #1;
        chk("rst_min_sad", min_sad, 32'h3FFF);
        chk("rst_min_tag", min_tag, 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd_data", rd_data, 32'h0);
        Reset = 0;

        // Basic run
        set_basic(32'h12101010, 32'h10101010);
        load_win();
        run(32'h100, 0, 0, lat);
        chk("basic_latency", 32'(lat), 32'd17);
        chk("basic_model_acc0", 32'(m_sads[0]), 32'd32);
        chk("basic_model_acc1", 32'(m_sads[1]), 32'd0);
        chk("basic_min_sad", min_sad, 32'd0);
        chk("basic_min_tag", min_tag, 32'h200);

        // Tie: channel 0 wins, but 16 is not below the held 0
        set_basic(32'h11101010, 32'h11101010);
        run(32'h100, 0, 0, lat);
        chk("tie_model_acc0", 32'(m_sads[0]), 32'd16);
        chk("tie_model_tag", m_best_tag, 32'h100);
        chk("tie_min_sad", min_sad, 32'd0);
        chk("tie_min_tag", min_tag, 32'h200);
        pulse_clear();
        run(32'h100, 0, 0, lat);
        chk("tie2_min_sad", min_sad, 32'd16);
        chk("tie2_min_tag", min_tag, 32'h100);

        // Stalls after beats 4 and 11
        set_basic(32'h12101010, 32'h10101010);
        stall_tab[3] = 3; stall_tab[10] = 3;
        pulse_clear();
        run(32'h100, 0, 0, lat);
        chk("stall_latency", 32'(lat), 32'd23);
        chk("stall_min_sad", min_sad, 32'd0);
        chk("stall_min_tag", min_tag, 32'h200);

        // Reset in the middle of accumulation
        set_basic(32'h12101010, 32'h10101010);
        base_tag = 32'h100; start = 1; tick(); start = 0;
        for (int i = 0; i < 7; i++) begin
            frm_valid = 1; frm_data = {frm_tab[i][1], frm_tab[i][0]}; tick();
        end
        frm_valid = 0;
        Reset = 1; #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_min_sad", min_sad, 32'h3FFF);
        tick(); Reset = 0;
        load_win();
        run(32'h100, 0, 0, lat);
        chk("midrst_latency", 32'(lat), 32'd17);
        chk("midrst_min_sad2", min_sad, 32'd0);
        chk("midrst_min_tag2", min_tag, 32'h200);

        // clear_min on the same edge as the minimum update
        pulse_clear();
        run(32'h100, 0, 1, lat);
        chk("clrcol_min_sad", min_sad, 32'h3FFF);
        chk("clrcol_min_tag", min_tag, 32'h0);

        // win_shift and start noise while accumulating
        run(32'h100, 1, 0, lat);
        chk("noise_min_sad", min_sad, 32'd0);
        chk("noise_min_tag", min_tag, 32'h200);

        // Randomized runs
        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < WIN; i++) begin
                win_tab[i] = $urandom;
                for (int c = 0; c < NCH; c++)
                    frm_tab[i][c] = ($urandom_range(0, 2) == 0) ? win_tab[i]
                                                               : (win_tab[i] ^ ($urandom & 32'h0F0F0F0F));
                if ($urandom_range(0, 3) == 0) frm_tab[i][1] = frm_tab[i][0];
                stall_tab[i] = (i == WIN-1) ? 0 : (($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0);
            end
            if ($urandom_range(0, 3) == 0) pulse_clear();
            load_win();
            run($urandom, 1'($urandom), 1'($urandom_range(0, 5) == 0), lat);
        end

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
